risk_alert_fsm: RTL and testbench

Consumer of the 8-bit driver risk score stream produced by the scoring core. Smooths the score with a power-of-two moving average and classifies the driver as SAFE, WARN or DANGER. Classification uses hysteresis and a dwell requirement before escalating. Each escalation raises an alert request that is held until the cabin controller acknowledges it.

---
 rtl/risk_alert_fsm.sv | 155 +++++++++++++++
 tb/tb_risk_alert_fsm.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risk_alert_fsm.sv
// -----------------------------------------------------------------------------
// risk_alert_fsm
//   Smooths the 8-bit driver risk score with a 2^WIN_LOG2-sample moving average
//   and classifies the driver as SAFE / WARN / DANGER. Escalation needs DWELL
//   consecutive escalating samples; de-escalation uses hysteresis thresholds
//   and happens on a single sample. Every escalation raises an alert request
//   that stays up until the cabin controller acknowledges it.
//
// Ports
//   clk          in   clock
//   rst          in   asynchronous, active-low reset
//   score_valid  in   score carries a new sample this cycle
//   score        in   [7:0] unsigned risk score
//   alert_ack    in   controller acknowledge of the pending alert
//   avg          out  [7:0] current moving average (registered sum >> WIN_LOG2)
//   level        out  [1:0] 0=SAFE, 1=WARN, 2=DANGER
//   alert_req    out  alert pending
//   alert_level  out  [1:0] level that raised the pending alert
// -----------------------------------------------------------------------------
module risk_alert_fsm #(
  parameter int WIN_LOG2   = 3,
  parameter int WARN_ON    = 100,
  parameter int WARN_OFF   = 80,
  parameter int DANGER_ON  = 180,
  parameter int DANGER_OFF = 150,
  parameter int DWELL      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       score_valid,
  input  logic [7:0] score,
  input  logic       alert_ack,
  output logic [7:0] avg,
  output logic [1:0] level,
  output logic       alert_req,
  output logic [1:0] alert_level
);

  localparam int WIN   = 1 << WIN_LOG2;
  localparam int SUM_W = 8 + WIN_LOG2;
  localparam int CNT_W = (DWELL < 2) ? 1 : $clog2(DWELL + 1);

  localparam logic [1:0] SAFE   = 2'd0;
  localparam logic [1:0] WARN   = 2'd1;
  localparam logic [1:0] DANGER = 2'd2;

  localparam logic [7:0] L_WARN_ON    = 8'(WARN_ON);
  localparam logic [7:0] L_WARN_OFF   = 8'(WARN_OFF);
  localparam logic [7:0] L_DANGER_ON  = 8'(DANGER_ON);
  localparam logic [7:0] L_DANGER_OFF = 8'(DANGER_OFF);
  localparam logic [CNT_W-1:0] L_DWELL_LAST = CNT_W'(DWELL - 1);

  // Sample window: index 0 is the newest sample, WIN-1 the oldest.
  logic [WIN-1:0][7:0] r_buf;
  logic [SUM_W-1:0]    r_sum;
  logic [CNT_W-1:0]    r_dwell;
  logic [1:0]          r_level;
  logic                r_alert_req;
  logic [1:0]          r_alert_level;

  logic [SUM_W-1:0]    w_next_sum;
  logic [7:0]          w_next_avg;
  logic [1:0]          w_target;
  logic [CNT_W-1:0]    w_dwell_next;
  logic [1:0]          w_level_next;
  logic                w_escalate;
  logic                w_alert_req_next;
  logic [1:0]          w_alert_level_next;

  // The oldest sample is always part of the sum, so the subtraction never
  // underflows and the sum never exceeds WIN*255.
  assign w_next_sum = r_sum + SUM_W'(score) - SUM_W'(r_buf[WIN-1]);
  assign w_next_avg = w_next_sum[SUM_W-1:WIN_LOG2];

  always_comb begin
    if (w_next_avg >= L_DANGER_ON)    w_target = DANGER;
    else if (w_next_avg >= L_WARN_ON) w_target = WARN;
    else                              w_target = SAFE;
  end

  // Window shift register and running sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf <= '0;
      r_sum <= '0;
    end else if (score_valid) begin
      for (int i = WIN - 1; i > 0; i--) r_buf[i] <= r_buf[i-1];
      r_buf[0] <= score;
      r_sum    <= w_next_sum;
    end
  end

  // State register: classification level, dwell counter and alert handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level       <= SAFE;
      r_dwell       <= '0;
      r_alert_req   <= 1'b0;
      r_alert_level <= SAFE;
    end else begin
      r_level       <= w_level_next;
      r_dwell       <= w_dwell_next;
      r_alert_req   <= w_alert_req_next;
      r_alert_level <= w_alert_level_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_level_next       = r_level;
    w_dwell_next       = r_dwell;
    w_escalate         = 1'b0;
    w_alert_req_next   = r_alert_req;
    w_alert_level_next = r_alert_level;

    if (score_valid) begin
      if (w_target > r_level) begin
        // The escalating level is whatever this last sample targets, which
        // allows SAFE straight to DANGER.
        if (r_dwell == L_DWELL_LAST) begin
          w_level_next = w_target;
          w_dwell_next = '0;
          w_escalate   = 1'b1;
        end else begin
          w_dwell_next = r_dwell + 1'b1;
        end
      end else begin
        // target <= level here, so any de-escalation also clears the count.
        w_dwell_next = '0;
        if (r_level == DANGER && w_next_avg < L_DANGER_OFF) begin
          w_level_next = (w_next_avg < L_WARN_OFF) ? SAFE : WARN;
        end else if (r_level == WARN && w_next_avg < L_WARN_OFF) begin
          w_level_next = SAFE;
        end
      end
    end

    // A new escalation takes priority over a coincident acknowledge.
    if (w_escalate) begin
      w_alert_req_next   = 1'b1;
      w_alert_level_next = w_level_next;
    end else if (alert_ack && r_alert_req) begin
      w_alert_req_next = 1'b0;
    end
  end

  // Outputs.
  always_comb begin
    avg         = r_sum[SUM_W-1:WIN_LOG2];
    level       = r_level;
    alert_req   = r_alert_req;
    alert_level = r_alert_level;
  end

endmodule

// File: tb/tb_risk_alert_fsm.sv
module tb_risk_alert_fsm;

  localparam int WIN_LOG2   = 3;
  localparam int WIN        = 1 << WIN_LOG2;
  localparam int WARN_ON    = 100;
  localparam int WARN_OFF   = 80;
  localparam int DANGER_ON  = 180;
  localparam int DANGER_OFF = 150;
  localparam int DWELL      = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       score_valid = 1'b0;
  logic [7:0] score = 8'd0;
  logic       alert_ack = 1'b0;
  logic [7:0] avg;
  logic [1:0] level;
  logic       alert_req;
  logic [1:0] alert_level;

  risk_alert_fsm #(
    .WIN_LOG2(WIN_LOG2), .WARN_ON(WARN_ON), .WARN_OFF(WARN_OFF),
    .DANGER_ON(DANGER_ON), .DANGER_OFF(DANGER_OFF), .DWELL(DWELL)
  ) dut (
    .clk(clk), .rst(rst), .score_valid(score_valid), .score(score),
    .alert_ack(alert_ack), .avg(avg), .level(level),
    .alert_req(alert_req), .alert_level(alert_level)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural reference: window as a plain array averaged by division,
  // classification and handshake straight from the rules.
  int m_win [WIN];
  int m_avg, m_level, m_dwell, m_alevel;
  bit m_req;

  function automatic void model_reset();
    foreach (m_win[i]) m_win[i] = 0;
    m_avg = 0; m_level = 0; m_dwell = 0; m_alevel = 0; m_req = 1'b0;
  endfunction

  function automatic void model_step(bit v, int s, bit a);
    bit esc;
    int sum, na, target;
    esc = 1'b0;
    if (v) begin
      for (int i = WIN - 1; i > 0; i--) m_win[i] = m_win[i-1];
      m_win[0] = s;
      sum = 0;
      foreach (m_win[i]) sum += m_win[i];
      na = sum / WIN;
      target = (na >= DANGER_ON) ? 2 : (na >= WARN_ON) ? 1 : 0;
      if (target > m_level) begin
        m_dwell++;
        if (m_dwell == DWELL) begin
          m_level = target; m_dwell = 0; esc = 1'b1;
        end
      end else begin
        m_dwell = 0;
        if (m_level == 2 && na < DANGER_OFF) m_level = (na < WARN_OFF) ? 0 : 1;
        else if (m_level == 1 && na < WARN_OFF) m_level = 0;
      end
      m_avg = na;
    end
    if (esc) begin
      m_req = 1'b1; m_alevel = m_level;
    end else if (a && m_req) begin
      m_req = 1'b0;
    end
  endfunction

  function automatic logic [12:0] exp_bundle();
    return {8'(m_avg), 2'(m_level), m_req, 2'(m_alevel)};
  endfunction

  // One clock of stimulus; returns #1 after the accepting edge.
  task automatic drive(bit v, logic [7:0] s, bit a);
    score_valid = v; score = s; alert_ack = a;
    @(posedge clk); #1;
    model_step(v, int'(s), a);
    score_valid = 1'b0; alert_ack = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b0; score_valid = 1'b0; alert_ack = 1'b0;
    @(posedge clk); #1;
    model_reset();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [12:0] got;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      score_valid = 1'(($urandom_range(0, 1)));
      score       = 8'($urandom_range(0, 255));
      alert_ack   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      got = {avg, level, alert_req, alert_level};
      n_cmp++;
      $display("reset cycle %0d: outputs=%h", c, got);
      if (got !== 13'd0) begin
        n_err++;
        $display("FAIL reset_hold cycle %0d: got %h need 0", c, got);
      end
    end
    score_valid = 1'b0; alert_ack = 1'b0;
    model_reset();
    rst = 1'b1;
    drive(1'b1, 8'd200, 1'b0);
    got = {avg, level, alert_req, alert_level};
    n_cmp++;
    $display("reset first sample 200: avg=%0d level=%0d", avg, level);
    if (got !== {8'd25, 2'd0, 1'b0, 2'd0} || got !== exp_bundle()) begin
      n_err++;
      $display("FAIL reset_first_sample: got %h need %h", got, exp_bundle());
    end
  endtask

  task automatic test_warn_dwell();
    logic [12:0] got, lit;
    int ea;
    reset_dut();
    for (int k = 1; k <= 12; k++) begin
      drive(1'b1, 8'd120, 1'b0);
      ea  = (k <= 8) ? 15 * k : 120;
      lit = {8'(ea), (k >= 10) ? 2'd1 : 2'd0, (k >= 10), (k >= 10) ? 2'd1 : 2'd0};
      got = {avg, level, alert_req, alert_level};
      n_cmp++;
      $display("warn sample %0d: avg=%0d level=%0d req=%0b alvl=%0d", k, avg, level, alert_req, alert_level);
      if (got !== lit || got !== exp_bundle()) begin
        n_err++;
        $display("FAIL warn_dwell sample %0d: got %h need %h", k, got, lit);
      end
    end
  endtask

  task automatic test_gaps();
    logic [12:0] got, lit;
    int ea, gaps;
    reset_dut();
    for (int k = 1; k <= 12; k++) begin
      gaps = int'($urandom_range(0, 3));
      for (int g = 0; g < gaps; g++) drive(1'b0, 8'($urandom_range(0, 255)), 1'b0);
      drive(1'b1, 8'd120, 1'b0);
      ea  = (k <= 8) ? 15 * k : 120;
      lit = {8'(ea), (k >= 10) ? 2'd1 : 2'd0, (k >= 10), (k >= 10) ? 2'd1 : 2'd0};
      got = {avg, level, alert_req, alert_level};
      n_cmp++;
      $display("gaps sample %0d (gap %0d): avg=%0d level=%0d req=%0b", k, gaps, avg, level, alert_req);
      if (got !== lit || got !== exp_bundle()) begin
        n_err++;
        $display("FAIL gaps sample %0d: got %h need %h", k, got, lit);
      end
    end
  endtask

  task automatic test_danger_overwrite();
    logic [12:0] got, lit;
    logic [1:0] el;
    int ea;
    reset_dut();
    for (int k = 1; k <= 12; k++) begin
      drive(1'b1, 8'd200, 1'b0);
      ea  = (k <= 8) ? 25 * k : 200;
      el  = (k >= 11) ? 2'd2 : (k >= 7) ? 2'd1 : 2'd0;
      lit = {8'(ea), el, (k >= 7), el};
      got = {avg, level, alert_req, alert_level};
      n_cmp++;
      $display("danger sample %0d: avg=%0d level=%0d req=%0b alvl=%0d", k, avg, level, alert_req, alert_level);
      if (got !== lit || got !== exp_bundle()) begin
        n_err++;
        $display("FAIL danger_overwrite sample %0d: got %h need %h", k, got, lit);
      end
    end
  endtask

  task automatic test_hysteresis();
    logic [12:0] got;
    reset_dut();
    for (int k = 1; k <= 12; k++) drive(1'b1, 8'd120, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 8'd90, 1'b0);
      got = {avg, level, alert_req, alert_level};
      n_cmp++;
      $display("hyst 90 sample %0d: avg=%0d level=%0d req=%0b", k, avg, level, alert_req);
      if (level !== 2'd1 || alert_req !== 1'b1 || got !== exp_bundle()) begin
        n_err++;
        $display("FAIL hyst_hold sample %0d: got %h need %h", k, got, exp_bundle());
      end
    end
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, 8'd70, 1'b0);
      got = {avg, level, alert_req, alert_level};
      n_cmp++;
      $display("hyst 70 sample %0d: avg=%0d level=%0d req=%0b", k, avg, level, alert_req);
      if (level !== ((k >= 5) ? 2'd0 : 2'd1) || alert_req !== 1'b1 ||
          (k == 5 && avg !== 8'd77) || got !== exp_bundle()) begin
        n_err++;
        $display("FAIL hyst_drop sample %0d: got %h need %h", k, got, exp_bundle());
      end
    end
  endtask

  task automatic test_handshake();
    logic [12:0] got;
    reset_dut();
    for (int k = 1; k <= 10; k++) drive(1'b1, 8'd200, 1'b0);
    drive(1'b1, 8'd200, 1'b1);
    got = {avg, level, alert_req, alert_level};
    n_cmp++;
    $display("handshake ack with escalation: level=%0d req=%0b alvl=%0d", level, alert_req, alert_level);
    if (alert_req !== 1'b1 || alert_level !== 2'd2 || got !== exp_bundle()) begin
      n_err++;
      $display("FAIL ack_coincident: got %h need %h", got, exp_bundle());
    end
    drive(1'b0, 8'd0, 1'b1);
    n_cmp++;
    $display("handshake ack later: req=%0b", alert_req);
    if (alert_req !== 1'b0 || {avg, level, alert_req, alert_level} !== exp_bundle()) begin
      n_err++;
      $display("FAIL ack_clear: got req %0b need 0", alert_req);
    end
    drive(1'b0, 8'd0, 1'b1);
    n_cmp++;
    $display("handshake idle ack: req=%0b level=%0d", alert_req, level);
    if (alert_req !== 1'b0 || level !== 2'd2 || {avg, level, alert_req, alert_level} !== exp_bundle()) begin
      n_err++;
      $display("FAIL ack_idle: got req %0b level %0d", alert_req, level);
    end
    // Reset in mid-cycle with an alert pending: outputs must drop at once.
    reset_dut();
    for (int k = 1; k <= 7; k++) drive(1'b1, 8'd200, 1'b0);
    score_valid = 1'b1; score = 8'd200;
    #2 rst = 1'b0;
    #1;
    got = {avg, level, alert_req, alert_level};
    n_cmp++;
    $display("async reset mid-stream: outputs=%h", got);
    if (got !== 13'd0) begin
      n_err++;
      $display("FAIL async_reset: got %h need 0", got);
    end
    score_valid = 1'b0;
    @(posedge clk); #1;
    model_reset();
    rst = 1'b1;
    drive(1'b1, 8'd200, 1'b0);
    got = {avg, level, alert_req, alert_level};
    n_cmp++;
    $display("after reset sample 200: avg=%0d level=%0d", avg, level);
    if (got !== {8'd25, 2'd0, 1'b0, 2'd0}) begin
      n_err++;
      $display("FAIL reset_resume: got %h need %h", got, {8'd25, 2'd0, 1'b0, 2'd0});
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] got;
    int base, b;
    bit v, a;
    reset_dut();
    base = 40;
    for (int c = 0; c < 400; c++) begin
      if (c % 40 == 0) base = int'($urandom_range(0, 255));
      b = base + int'($urandom_range(0, 60)) - 30;
      if (b < 0) b = 0;
      if (b > 255) b = 255;
      v = ($urandom_range(0, 9) < 7);
      a = ($urandom_range(0, 4) == 0);
      drive(v, 8'(b), a);
      got = {avg, level, alert_req, alert_level};
      n_cmp++;
      $display("rand %0d v=%0b s=%0d ack=%0b: avg=%0d level=%0d req=%0b alvl=%0d",
               c, v, b, a, avg, level, alert_req, alert_level);
      if (got !== exp_bundle()) begin
        n_err++;
        $display("FAIL random cycle %0d: got %h need %h", c, got, exp_bundle());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_warn_dwell();
    test_gaps();
    test_danger_overwrite();
    test_hysteresis();
    test_handshake();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
